// File: rtl/voltage_descaler.sv
// ============================================================================
// voltage_descaler
// ----------------------------------------------------------------------------
// Converts a requested voltage in millivolts into the equivalent 12-bit ADC
// code: out_code = floor(in_mv * NUM / DEN), saturating at 4095. This is the
// inverse of the code-to-millivolt scaler used elsewhere in the lab designs.
//
// The conversion is multi-cycle: one cycle to form the 32-bit product, then a
// restoring divider producing one quotient bit per cycle (MSB first), then a
// final cycle that clamps the quotient and registers the result. A request
// accepted at edge N produces out_valid after edge N+34.
//
// Optional feature (compile-time macro):
//   VOLTAGE_DESCALER_ROUND_EN  - when defined, DEN/2 is added to the product
//                                before division (round-half-up). When not
//                                defined the result truncates toward zero.
//                                Latency is identical in both builds.
//
// Parameters:
//   NUM        numerator scale constant applied to the millivolt input
//   DEN        divisor; LSB weight of one ADC code in micro-millivolts
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (aborts any conversion)
//   in_mv      requested voltage in millivolts (unsigned, 12 bits)
//   in_valid   in_mv is valid this cycle
//   in_ready   block accepts a request this cycle (IDLE only)
//   out_code   12-bit ADC code result
//   out_sat    result was clamped to 4095
//   out_valid  out_code/out_sat valid (DONE only)
//   out_ready  consumer accepts the result this cycle
// ============================================================================
module voltage_descaler #(
    parameter int unsigned NUM = 1_000_000,
    parameter int unsigned DEN = 805_664
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] in_mv,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] out_code,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] NUM_W      = 32'(NUM);
    localparam logic [31:0] DEN_W      = 32'(DEN);
    localparam logic [32:0] DEN_WIDE   = 33'(DEN);
`ifdef VOLTAGE_DESCALER_ROUND_EN
    localparam logic [31:0] ROUND_BIAS = 32'(DEN / 2);
`endif

    // Division runs for 32 bit-steps; the step counter reaching this value
    // marks the extra finalize cycle that clamps and registers the result.
    localparam logic [5:0] DIV_STEPS = 6'd32;

    state_t      state;
    state_t      state_next;

    logic [11:0] mv_hold;
    logic [31:0] work;
    logic [31:0] rem;
    logic [5:0]  step_count;
    logic [11:0] code_reg;
    logic        sat_reg;

    logic [31:0] product;
    logic [32:0] trial;
    logic        trial_fits;
    logic [31:0] trial_diff;
    logic        quotient_over;

    // Product of the held millivolt value and the scale constant. The widest
    // case (4095 * 1_000_000, plus DEN/2 when rounding) still fits in 32 bits.
    always_comb begin
`ifdef VOLTAGE_DESCALER_ROUND_EN
        product = (32'(mv_hold) * NUM_W) + ROUND_BIAS;
`else
        product = 32'(mv_hold) * NUM_W;
`endif
    end

    // One restoring-division step. The partial remainder is shifted left by
    // one and the next dividend bit (MSB of the work register) brought in.
    // The comparison is made at 33 bits because the shifted remainder can
    // exceed 32 bits before the subtraction. When the trial fits, the true
    // difference is below DEN, so its low 32 bits are exact.
    always_comb begin
        trial         = {rem, work[31]};
        trial_fits    = (trial >= DEN_WIDE);
        trial_diff    = trial[31:0] - DEN_W;
        quotient_over = |work[31:12];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. A result handshake always returns to
    // IDLE first, so a new request can only be taken on a later edge.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                state_next = DIV;
            end
            DIV: begin
                if (step_count == DIV_STEPS) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. The work register first holds the product (the dividend);
    // during division it shifts left, dropping dividend bits off the top and
    // taking quotient bits in at the bottom, so after 32 steps it holds the
    // full quotient. The held input and result registers only change in the
    // states that own them, so inputs arriving while busy are ignored and
    // the result stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            mv_hold    <= '0;
            work       <= '0;
            rem        <= '0;
            step_count <= '0;
            code_reg   <= '0;
            sat_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mv_hold <= in_mv;
                    end
                end
                MUL: begin
                    work       <= product;
                    rem        <= '0;
                    step_count <= '0;
                end
                DIV: begin
                    if (step_count != DIV_STEPS) begin
                        rem        <= trial_fits ? trial_diff : trial[31:0];
                        work       <= {work[30:0], trial_fits};
                        step_count <= step_count + 6'd1;
                    end else begin
                        code_reg <= quotient_over ? 12'hFFF : work[11:0];
                        sat_reg  <= quotient_over;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_code = code_reg;
    assign out_sat  = sat_reg;

endmodule

// File: tb/tb_voltage_descaler.sv
// ============================================================================
// tb_voltage_descaler
// ----------------------------------------------------------------------------
// Self-checking bench for voltage_descaler. Expected codes come from a
// behavioural model using 64-bit integer arithmetic on the conversion
// formula (with the DEN/2 bias when VOLTAGE_DESCALER_ROUND_EN is defined),
// followed by the 4095 clamp. Directed cases cover the documented reference
// points, a consumer stall with ignored busy requests, a mid-division reset,
// back-to-back throughput, plus a batch of random millivolt values.
// ============================================================================
module tb_voltage_descaler;

    localparam int unsigned NUM = 1_000_000;
    localparam int unsigned DEN = 805_664;
    localparam int          EXPECTED_LATENCY = 34;
    localparam int          EXPECTED_SPACING = 36;

    logic        clk;
    logic        rst;
    logic [11:0] in_mv;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_code;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;

    int errors;
    int checks;

    voltage_descaler #(
        .NUM(NUM),
        .DEN(DEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_mv    (in_mv),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_code (out_code),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion straight from the formula.
    task automatic ref_model(input logic [11:0] mv, output logic [31:0] code, output logic [31:0] sat);
        longint unsigned p;
        longint unsigned q;
        p = longint'(mv) * longint'(NUM);
`ifdef VOLTAGE_DESCALER_ROUND_EN
        p = p + longint'(DEN / 2);
`endif
        q = p / longint'(DEN);
        if (q > 64'd4095) begin
            code = 32'd4095;
            sat  = 32'd1;
        end else begin
            code = 32'(q);
            sat  = 32'd0;
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Offer one request from IDLE and wait (bounded) for the result.
    // Returns the number of edges from acceptance to out_valid, 0 on timeout.
    task automatic apply_stimulus(input logic [11:0] mv, output int latency);
        check_value("in_ready_before_request", 32'(in_ready), 32'd1);
        in_mv    = mv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        latency  = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                latency = n;
                break;
            end
        end
    endtask

    // Compare the held result against the model, then complete the handshake.
    task automatic check_output(input string tag, input logic [11:0] mv, input int latency);
        logic [31:0] exp_code;
        logic [31:0] exp_sat;
        ref_model(mv, exp_code, exp_sat);
        check_value({tag, "_latency"}, 32'(latency), 32'(EXPECTED_LATENCY));
        check_value({tag, "_code"}, 32'(out_code), exp_code);
        check_value({tag, "_sat"}, 32'(out_sat), exp_sat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_value({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_value({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          latency;
        int          gap;
        logic        seen_low;
        logic        seen_valid;
        logic [11:0] mv;
        logic [31:0] exp_code;
        logic [31:0] exp_sat;

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_mv     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_in_ready", 32'(in_ready), 32'd1);
        check_value("reset_out_valid", 32'(out_valid), 32'd0);
        check_value("reset_out_code", 32'(out_code), 32'd0);
        check_value("reset_out_sat", 32'(out_sat), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reference points: mid-scale, near full-scale, saturation, zero.
        apply_stimulus(12'd1650, latency);
        check_output("mv1650", 12'd1650, latency);
        apply_stimulus(12'd3299, latency);
        check_output("mv3299", 12'd3299, latency);
        apply_stimulus(12'd4095, latency);
        check_output("mv4095", 12'd4095, latency);
        apply_stimulus(12'd0, latency);
        check_output("mv0", 12'd0, latency);

        // Random millivolt values over the full input range.
        for (int i = 0; i < 16; i++) begin
            mv = 12'($urandom_range(0, 4095));
            apply_stimulus(mv, latency);
            check_output("random", mv, latency);
        end

        // Stall: busy-time requests of 2000 must be ignored, and the result
        // must hold while out_ready stays low for 10 cycles.
        ref_model(12'd1000, exp_code, exp_sat);
        check_value("stall_in_ready_idle", 32'(in_ready), 32'd1);
        in_mv    = 12'd1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        latency = 0;
        for (int n = 1; n <= 100; n++) begin
            in_mv    = 12'd2000;
            in_valid = n[0];
            @(posedge clk);
            #1;
            if (n == 5) begin
                check_value("stall_busy_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid) begin
                latency = n;
                break;
            end
        end
        for (int n = 0; n < 10; n++) begin
            in_mv    = 12'd2000;
            in_valid = n[0];
            @(posedge clk);
            #1;
            check_value("stall_hold_valid", 32'(out_valid), 32'd1);
            check_value("stall_hold_code", 32'(out_code), exp_code);
        end
        in_valid = 1'b0;
        check_output("stall_mv1000", 12'd1000, latency);

        // Reset in the 15th division cycle, with in_valid also high to show
        // reset wins. The aborted conversion must never produce out_valid.
        in_mv    = 12'd1500;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_value("abort_in_ready", 32'(in_ready), 32'd1);
        check_value("abort_out_valid", 32'(out_valid), 32'd0);
        check_value("abort_out_code", 32'(out_code), 32'd0);
        seen_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check_value("abort_no_result", 32'(seen_valid), 32'd0);
        apply_stimulus(12'd1650, latency);
        check_output("after_abort_mv1650", 12'd1650, latency);

        // Back-to-back with in_valid and out_ready held high.
        check_value("b2b_in_ready_idle", 32'(in_ready), 32'd1);
        in_mv     = 12'd1000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_mv   = 12'd1650;
        latency = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                latency = n;
                break;
            end
        end
        ref_model(12'd1000, exp_code, exp_sat);
        check_value("b2b_first_latency", 32'(latency), 32'(EXPECTED_LATENCY));
        check_value("b2b_first_code", 32'(out_code), exp_code);
        gap      = 0;
        seen_low = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (!out_valid) begin
                seen_low = 1'b1;
            end else if (seen_low) begin
                gap = n;
                break;
            end
        end
        in_valid = 1'b0;
        ref_model(12'd1650, exp_code, exp_sat);
        check_value("b2b_spacing", 32'(gap), 32'(EXPECTED_SPACING));
        check_value("b2b_second_code", 32'(out_code), exp_code);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_value("b2b_valid_drop", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/voltage_descaler.md
VOLTAGE_DESCALER -- requirements
Module: voltage_descaler

Interface
REQ-001 Parameter NUM, default 1_000_000, numerator scale constant applied to input millivolts.
REQ-002 Parameter DEN, default 805_664, divisor; LSB weight of one ADC code in micro-millivolts (805.664 uV per code).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_mv  input  12  requested voltage in millivolts, unsigned.
REQ-006 in_valid  input  1  in_mv is valid this cycle.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 out_code  output  12  12-bit ADC code equivalent of in_mv.
REQ-009 out_sat  output  1  result was clamped to 4095.
REQ-010 out_valid  output  1  out_code/out_sat valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-012 Computes out_code = floor(in_mv*NUM/DEN), the inverse of the team's code-to-millivolt scaler.
REQ-013 FSM states IDLE, MUL, DIV, DONE; one-hot or binary encoding is an implementation choice.
REQ-014 IDLE: in_ready=1; when in_valid&&in_ready at an edge, in_mv is captured and the state goes to MUL.
REQ-015 MUL: 32-bit product in_mv*NUM registered in one cycle; next state DIV.
REQ-016 DIV: restoring division, one quotient bit per cycle, exactly 32 cycles, MSB first; 32-bit remainder held with at least 33-bit compare width.
REQ-017 DONE: out_valid=1; out_code and out_sat are held stable until out_valid&&out_ready at an edge, then the state returns to IDLE.
REQ-018 Latency: accept at edge N -> out_valid first high after edge N+34.
REQ-019 If quotient > 4095: out_code=4095, out_sat=1; otherwise out_code=quotient[11:0], out_sat=0.
REQ-020 in_ready=0 in MUL, DIV, DONE; in_valid in those states is ignored and the held input is not modified.
REQ-021 out_valid=0 in every state except DONE; out_ready outside DONE has no effect.
REQ-022 Same-cycle completion and new request is not supported: after the out handshake, the block spends at least one cycle in IDLE before accepting.
REQ-023 Throughput: one result per 36 cycles minimum with in_valid and out_ready held high.

Reset
REQ-024 rst at any edge forces IDLE: in_ready=1, out_valid=0, out_code=0, out_sat=0; all internal registers are cleared.
REQ-025 rst asserted mid-operation (MUL/DIV/DONE) aborts the conversion; no out_valid is produced for it.
REQ-026 rst has priority over simultaneous in_valid or out_ready.

Configuration
REQ-027 Macro VOLTAGE_DESCALER_ROUND_EN.
REQ-028 Defined: DEN/2 (integer) is added to the product in MUL before division, giving round-half-up; max sum 4_095_402_832 fits in 32 bits.
REQ-029 Undefined: no addition is made; the result truncates toward zero; latency is identical in both builds.

Verification
REQ-030 in_mv=1650 -> out_code=2048, out_sat=0 in both builds; out_valid rises 34 edges after accept.
REQ-031 in_mv=3299 -> out_code=4094 without ROUND_EN, 4095 with ROUND_EN; out_sat=0.
REQ-032 in_mv=4095 -> quotient 5082 -> out_code=4095, out_sat=1; in_mv=0 -> out_code=0.
REQ-033 in_mv=1000 accepted; out_ready held 0 for 10 cycles -> out_valid and out_code=1241 stay stable; in_valid pulses with in_mv=2000 during busy are ignored.
REQ-034 rst pulsed in the 15th DIV cycle -> next cycle in_ready=1, out_valid=0; the following request in_mv=1650 returns 2048 with normal latency.
REQ-035 Back-to-back: in_valid and out_ready held high, inputs 1000, 1650 -> results 1241, 2048 in order, spaced 36 cycles apart.
